// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the LED-panel UART receiver and transmitter.
//   uart_state_e - line-side FSM state encoding (IDLE/START/DATA/STOP)
//   FRAME_BITS   - bits per 8N1 frame (start + 8 data + stop)
//   clk_div()    - clock cycles per bit for a given clock and baud rate
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int FRAME_BITS = 10;

  // Integer division is intentional: the residual baud error is absorbed
  // by sampling at the bit centre.
  function automatic int clk_div(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: single-bit two-flop synchronizer for an asynchronous input.
//   clk   - destination clock
//   rst   - synchronous active-high reset; both flops load RESET_VAL
//   d     - asynchronous input
//   q     - synchronized output (two cycles of latency)
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] stage_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= {2{RESET_VAL}};
    end else begin
      stage_q <= {stage_q[0], d};
    end
  end

  assign q = stage_q[1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver for the LED-panel host link.
//   clk       - system clock, rising edge
//   rst       - synchronous active-high reset
//   rx        - asynchronous serial input, idle high
//   data      - last correctly received byte, held until the next good byte
//   valid     - one-cycle pulse, data updated this cycle
//   frame_err - one-cycle pulse, stop bit sampled low (data unchanged)
//   busy      - high whenever the receiver is not idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 25000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CLK_DIV = clk_div(CLK_FREQ, BAUD_RATE);
  localparam int HALF    = CLK_DIV / 2;

  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF - 1);

  // Below 4 the half-bit count collapses; above 65535 clk_cnt overflows.
  cfg_clk_div_legal : assert property (@(posedge clk)
    (CLK_DIV >= 4) && (CLK_DIV <= 65535));

  logic rx_s;
  logic rx_dly_q;

  uart_state_e state_q, state_d;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        frame_err_q, frame_err_d;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_dly_q    <= 1'b1;
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_dly_q    <= rx_s;
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        bit_idx_d = '0;
        // Only a high-to-low transition starts a frame, so a line held low
        // after a break cannot retrigger.
        if (rx_dly_q && !rx_s) begin
          state_d = START;
        end
      end

      START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          // A start bit that is high again at its centre was a glitch.
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end

      DATA: begin
        if (clk_cnt_q == DIV_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end

      STOP: begin
        if (clk_cnt_q == DIV_LAST) begin
          clk_cnt_d = '0;
          // Leaving at mid-stop-bit leaves half a bit of margin to catch
          // the next start edge of a back-to-back frame.
          state_d   = IDLE;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(
    .CLK_FREQ (16),
    .BAUD_RATE(1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] last_good = 8'h00;
  int         total = 0;
  int         bad = 0;
  int         n_valid = 0;
  int         n_ferr = 0;
  int         last_pulse_cyc = 0;
  int         valid_cycs[$];
  int         send_start_cyc = 0;
  logic       prev_pulse = 1'b0;

  // Expected pulse for a frame; a framing error must leave data unchanged.
  task automatic push_exp(input bit is_err, input logic [7:0] d);
    exp_t e;
    e.is_err = is_err;
    e.data   = is_err ? last_good : d;
    if (!is_err) last_good = d;
    sb.push_back(e);
  endtask

  // Bit-banged 8N1 frame; caller is aligned to a negedge and stays so.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    send_start_cyc = cyc;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stop_bit;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
  endtask

  // Scoreboard monitor: every pulse is checked against the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (valid || frame_err) begin
        total++;
        if (valid && frame_err) begin
          bad++;
          $display("FAIL pulse_excl: valid=%b frame_err=%b want not both", valid, frame_err);
        end
        total++;
        if (prev_pulse) begin
          bad++;
          $display("FAIL pulse_consec: pulse at cycle %0d follows a pulse, want gap", cyc);
        end
        if (valid) begin
          n_valid++;
          valid_cycs.push_back(cyc);
        end
        if (frame_err) n_ferr++;
        last_pulse_cyc = cyc;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: valid=%b frame_err=%b data=%h want no pulse",
                   valid, frame_err, data);
        end else begin
          total++;
          if (frame_err !== sb[0].is_err) begin
            bad++;
            $display("FAIL sb_kind: frame_err=%b want %b", frame_err, sb[0].is_err);
          end
          total++;
          if (data !== sb[0].data) begin
            bad++;
            $display("FAIL sb_data: data=%h want %h", data, sb[0].data);
          end
          void'(sb.pop_front());
        end
      end
      prev_pulse = valid | frame_err;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (data !== 8'h00)   begin bad++; $display("FAIL reset_data: got %h want 00", data); end
    total++; if (valid !== 1'b0)   begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    $display("reset: data=%h valid=%b frame_err=%b busy=%b", data, valid, frame_err, busy);
  endtask

  task automatic test_single();
    int sv, sf, lat;
    sv = n_valid; sf = n_ferr;
    push_exp(1'b0, 8'hA5);
    send_frame(8'hA5, 1'b1);
    repeat (4) @(negedge clk);
    lat = last_pulse_cyc - send_start_cyc;
    total++; if (n_valid - sv !== 1) begin bad++; $display("FAIL single_valid_cnt: got %0d want 1", n_valid - sv); end
    total++; if (n_ferr - sf !== 0)  begin bad++; $display("FAIL single_ferr_cnt: got %0d want 0", n_ferr - sf); end
    total++; if (data !== 8'hA5)     begin bad++; $display("FAIL single_data: got %h want a5", data); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL single_busy: got %b want 0", busy); end
    total++; if (lat < 154 || lat > 156) begin bad++; $display("FAIL single_latency: got %0d want 155+-1", lat); end
    total++; if (sb.size() != 0)     begin bad++; $display("FAIL single_pending: got %0d want 0", sb.size()); end
    $display("single: byte a5 data=%h latency=%0d", data, lat);
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h81;
    valid_cycs.delete();
    for (int i = 0; i < 3; i++) push_exp(1'b0, bytes[i]);
    for (int i = 0; i < 3; i++) send_frame(bytes[i], 1'b1);
    repeat (4) @(negedge clk);
    total++;
    if (valid_cycs.size() != 3) begin
      bad++; $display("FAIL b2b_count: got %0d want 3", valid_cycs.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        total++;
        if (valid_cycs[i] - valid_cycs[i-1] < 160) begin
          bad++; $display("FAIL b2b_spacing: got %0d want >=160", valid_cycs[i] - valid_cycs[i-1]);
        end
      end
    end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL b2b_pending: got %0d want 0", sb.size()); end
    $display("back_to_back: bytes 00 ff 81 valids=%0d last data=%h", valid_cycs.size(), data);
  endtask

  task automatic test_glitch();
    int sv, sf;
    logic saw_busy;
    sv = n_valid; sf = n_ferr; saw_busy = 1'b0;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (30) begin
      @(negedge clk);
      saw_busy = saw_busy | busy;
    end
    total++; if (saw_busy !== 1'b1)  begin bad++; $display("FAIL glitch_busy_seen: got %b want 1", saw_busy); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL glitch_busy_end: got %b want 0", busy); end
    total++; if (n_valid - sv !== 0) begin bad++; $display("FAIL glitch_valid_cnt: got %0d want 0", n_valid - sv); end
    total++; if (n_ferr - sf !== 0)  begin bad++; $display("FAIL glitch_ferr_cnt: got %0d want 0", n_ferr - sf); end
    $display("glitch: 3-cycle low, busy_seen=%b busy=%b", saw_busy, busy);
  endtask

  task automatic test_framing();
    int sv, sf;
    sv = n_valid; sf = n_ferr;
    push_exp(1'b0, 8'h11);
    send_frame(8'h11, 1'b1);
    push_exp(1'b1, 8'h3C);
    send_frame(8'h3C, 1'b0);
    repeat (2 * DIV) @(negedge clk);
    total++; if (data !== 8'h11)     begin bad++; $display("FAIL frame_data: got %h want 11", data); end
    total++; if (n_valid - sv !== 1) begin bad++; $display("FAIL frame_valid_cnt: got %0d want 1", n_valid - sv); end
    total++; if (n_ferr - sf !== 1)  begin bad++; $display("FAIL frame_ferr_cnt: got %0d want 1", n_ferr - sf); end
    total++; if (sb.size() != 0)     begin bad++; $display("FAIL frame_pending: got %0d want 0", sb.size()); end
    $display("framing: 11 then 3c with low stop, data=%h", data);
  endtask

  task automatic test_break();
    int sv, sf;
    sv = n_valid; sf = n_ferr;
    push_exp(1'b1, 8'h00);
    rx = 1'b0;
    repeat (40 * DIV) @(negedge clk);
    rx = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    total++; if (n_ferr - sf !== 1)  begin bad++; $display("FAIL break_ferr_cnt: got %0d want 1", n_ferr - sf); end
    push_exp(1'b0, 8'h5A);
    send_frame(8'h5A, 1'b1);
    repeat (4) @(negedge clk);
    total++; if (n_valid - sv !== 1) begin bad++; $display("FAIL break_valid_cnt: got %0d want 1", n_valid - sv); end
    total++; if (data !== 8'h5A)     begin bad++; $display("FAIL break_data: got %h want 5a", data); end
    total++; if (sb.size() != 0)     begin bad++; $display("FAIL break_pending: got %0d want 0", sb.size()); end
    $display("break: 40 bit times low then 5a, data=%h", data);
  endtask

  task automatic test_reset_mid();
    int sv, sf;
    logic [7:0] b;
    b = 8'hC3;
    sv = n_valid; sf = n_ferr;
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    total++; if (data !== 8'h00)     begin bad++; $display("FAIL rstmid_data: got %h want 00", data); end
    total++; if (valid !== 1'b0)     begin bad++; $display("FAIL rstmid_valid: got %b want 0", valid); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rstmid_ferr: got %b want 0", frame_err); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    rst = 1'b0;
    last_good = 8'h00;
    repeat (20 * DIV) @(negedge clk);
    total++; if (n_valid - sv !== 0) begin bad++; $display("FAIL rstmid_valid_cnt: got %0d want 0", n_valid - sv); end
    total++; if (n_ferr - sf !== 0)  begin bad++; $display("FAIL rstmid_ferr_cnt: got %0d want 0", n_ferr - sf); end
    push_exp(1'b0, 8'h7E);
    send_frame(8'h7E, 1'b1);
    repeat (4) @(negedge clk);
    total++; if (data !== 8'h7E)     begin bad++; $display("FAIL rstmid_next_data: got %h want 7e", data); end
    total++; if (n_valid - sv !== 1) begin bad++; $display("FAIL rstmid_next_cnt: got %0d want 1", n_valid - sv); end
    total++; if (sb.size() != 0)     begin bad++; $display("FAIL rstmid_pending: got %0d want 0", sb.size()); end
    $display("reset_mid: c3 aborted, then 7e data=%h", data);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_break();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
